// File: rtl/tpu_cmd_ctrl.sv
// Host command responder for the TPU: accepts one command at a time and sequences
// weight fill, FIFO drain, input streaming, output store and accumulator clear.
module tpu_cmd_ctrl #(
  parameter int WIDTH_HEIGHT = 16,
  parameter int DATA_WIDTH   = 8,
  parameter int MAX_MAT_WH   = 128
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic                                          start,
  input  logic [2:0]                                    opcode,
  input  logic [$clog2(WIDTH_HEIGHT)-1:0]               dim_1,
  input  logic [$clog2(WIDTH_HEIGHT)-1:0]               dim_2,
  input  logic [$clog2(WIDTH_HEIGHT)-1:0]               dim_3,
  input  logic [7:0]                                    addr_1,
  input  logic [$clog2(MAX_MAT_WH/WIDTH_HEIGHT)-1:0]    accum_table_submat_row_in,
  input  logic [$clog2(MAX_MAT_WH/WIDTH_HEIGHT)-1:0]    accum_table_submat_col_in,
  output logic                                          done,
  output logic                                          busy,
  output logic                                          cmd_err,
  output logic                                          fifo_ready,
  output logic                                          weightMem_rd_en,
  output logic [7:0]                                    weightMem_rd_addr,
  output logic                                          fifo_wr_en,
  output logic                                          fifo_drain_en,
  output logic                                          inputMem_rd_en,
  output logic [7:0]                                    inputMem_rd_addr,
  output logic                                          outputMem_wr_en,
  output logic [7:0]                                    outputMem_wr_addr,
  output logic                                          accum_clear,
  output logic [$clog2(MAX_MAT_WH/WIDTH_HEIGHT)-1:0]    accum_row,
  output logic [$clog2(MAX_MAT_WH/WIDTH_HEIGHT)-1:0]    accum_col,
  output logic [$clog2(WIDTH_HEIGHT)-1:0]               dim_2_q
);

  localparam int DW = $clog2(WIDTH_HEIGHT);
  // DATA_WIDTH only rides along for top-level passthrough; it does not shape the sequencer.
  localparam logic [7:0] DRAIN_LAST = 8'(WIDTH_HEIGHT - 1 + 0 * DATA_WIDTH);
  localparam logic [7:0] FLUSH_LAST = 8'(2 * WIDTH_HEIGHT - 2);

  typedef enum logic [3:0] {
    S_IDLE, S_FILL, S_FILL_TAIL, S_DRAIN, S_MULT_RD, S_MULT_FLUSH, S_STORE, S_CLEAR, S_DONE
  } state_e;

  state_e          state_q;
  logic [7:0]      cnt_q;
  logic [7:0]      addr_q;
  logic [DW-1:0]   dim1_q;
  logic [DW-1:0]   dim3_q;
  logic [7:0]      cnt_d;
  logic [7:0]      addr_d;

  // Next count and the address it maps to (latched base plus count, 8-bit wrap).
  always_comb begin
    cnt_d  = cnt_q + 8'd1;
    addr_d = addr_q + cnt_d;
  end

  // Command FSM with all outputs registered alongside the state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q           <= S_IDLE;
      cnt_q             <= 8'd0;
      addr_q            <= 8'd0;
      dim1_q            <= '0;
      dim3_q            <= '0;
      dim_2_q           <= '0;
      accum_row         <= '0;
      accum_col         <= '0;
      done              <= 1'b0;
      busy              <= 1'b0;
      cmd_err           <= 1'b0;
      fifo_ready        <= 1'b0;
      weightMem_rd_en   <= 1'b0;
      weightMem_rd_addr <= 8'd0;
      fifo_wr_en        <= 1'b0;
      fifo_drain_en     <= 1'b0;
      inputMem_rd_en    <= 1'b0;
      inputMem_rd_addr  <= 8'd0;
      outputMem_wr_en   <= 1'b0;
      outputMem_wr_addr <= 8'd0;
      accum_clear       <= 1'b0;
    end else begin
      done            <= 1'b0;
      weightMem_rd_en <= 1'b0;
      fifo_wr_en      <= weightMem_rd_en;  // weight memory has one cycle of read latency
      fifo_drain_en   <= 1'b0;
      inputMem_rd_en  <= 1'b0;
      outputMem_wr_en <= 1'b0;
      accum_clear     <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            addr_q    <= addr_1;
            dim1_q    <= dim_1;
            dim3_q    <= dim_3;
            dim_2_q   <= dim_2;
            accum_row <= accum_table_submat_row_in;
            accum_col <= accum_table_submat_col_in;
            cnt_q     <= 8'd0;
            busy      <= 1'b1;
            cmd_err   <= 1'b0;
            case (opcode)
              3'b000: begin
                state_q <= S_DONE;
                done    <= 1'b1;
              end
              3'b001: begin
                state_q           <= S_FILL;
                weightMem_rd_en   <= 1'b1;
                weightMem_rd_addr <= addr_1;
              end
              3'b010: begin
                // Draining an unfilled FIFO is refused rather than shifting garbage in.
                if (fifo_ready) begin
                  state_q       <= S_DRAIN;
                  fifo_drain_en <= 1'b1;
                  fifo_ready    <= 1'b0;
                end else begin
                  state_q <= S_DONE;
                  done    <= 1'b1;
                  cmd_err <= 1'b1;
                end
              end
              3'b011: begin
                state_q          <= S_MULT_RD;
                inputMem_rd_en   <= 1'b1;
                inputMem_rd_addr <= addr_1;
              end
              3'b100: begin
                state_q           <= S_STORE;
                outputMem_wr_en   <= 1'b1;
                outputMem_wr_addr <= addr_1;
              end
              3'b111: begin
                state_q     <= S_CLEAR;
                accum_clear <= 1'b1;
                fifo_ready  <= 1'b0;
              end
              default: begin
                state_q <= S_DONE;
                done    <= 1'b1;
                cmd_err <= 1'b1;
              end
            endcase
          end
        end
        S_FILL: begin
          if (cnt_q == 8'(dim1_q)) begin
            state_q <= S_FILL_TAIL;
          end else begin
            cnt_q             <= cnt_d;
            weightMem_rd_en   <= 1'b1;
            weightMem_rd_addr <= addr_d;
          end
        end
        S_FILL_TAIL: begin
          state_q    <= S_DONE;
          done       <= 1'b1;
          fifo_ready <= 1'b1;
        end
        S_DRAIN: begin
          if (cnt_q == DRAIN_LAST) begin
            state_q <= S_DONE;
            done    <= 1'b1;
          end else begin
            cnt_q         <= cnt_d;
            fifo_drain_en <= 1'b1;
          end
        end
        S_MULT_RD: begin
          if (cnt_q == 8'(dim1_q)) begin
            state_q <= S_MULT_FLUSH;
            cnt_q   <= 8'd0;
          end else begin
            cnt_q            <= cnt_d;
            inputMem_rd_en   <= 1'b1;
            inputMem_rd_addr <= addr_d;
          end
        end
        S_MULT_FLUSH: begin
          if (cnt_q == FLUSH_LAST) begin
            state_q <= S_DONE;
            done    <= 1'b1;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        S_STORE: begin
          if (cnt_q == 8'(dim3_q)) begin
            state_q <= S_DONE;
            done    <= 1'b1;
          end else begin
            cnt_q             <= cnt_d;
            outputMem_wr_en   <= 1'b1;
            outputMem_wr_addr <= addr_d;
          end
        end
        S_CLEAR: begin
          state_q <= S_DONE;
          done    <= 1'b1;
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy    <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tpu_cmd_ctrl.sv
// Directed self-checking bench for tpu_cmd_ctrl: issues host commands and checks
// enable counts, address sequences, done timing, busy and error flags.
module tb_tpu_cmd_ctrl;

  logic       clk;
  logic       reset;
  logic       start;
  logic [2:0] opcode;
  logic [3:0] dim_1, dim_2, dim_3;
  logic [7:0] addr_1;
  logic [2:0] row_in, col_in;
  logic       done, busy, cmd_err, fifo_ready;
  logic       weightMem_rd_en, fifo_wr_en, fifo_drain_en, inputMem_rd_en;
  logic       outputMem_wr_en, accum_clear;
  logic [7:0] weightMem_rd_addr, inputMem_rd_addr, outputMem_wr_addr;
  logic [2:0] accum_row, accum_col;
  logic [3:0] dim_2_q;

  int errors = 0;
  int checks = 0;

  // Per-command observations collected by run_cmd.
  int         done_cyc, n_done, n_wrd, n_fwr, lag_err, n_drain, n_inrd, n_outwr;
  int         n_clear, n_any_en, rc_err;
  logic       fr_k1, fr_done, busy_done, busy_after, done_after;
  logic [7:0] w_addr[0:31];
  logic [7:0] i_addr[0:31];
  logic [7:0] o_addr[0:31];

  tpu_cmd_ctrl #(.WIDTH_HEIGHT(16), .DATA_WIDTH(8), .MAX_MAT_WH(128)) dut (
    .clk                       (clk),
    .reset                     (reset),
    .start                     (start),
    .opcode                    (opcode),
    .dim_1                     (dim_1),
    .dim_2                     (dim_2),
    .dim_3                     (dim_3),
    .addr_1                    (addr_1),
    .accum_table_submat_row_in (row_in),
    .accum_table_submat_col_in (col_in),
    .done                      (done),
    .busy                      (busy),
    .cmd_err                   (cmd_err),
    .fifo_ready                (fifo_ready),
    .weightMem_rd_en           (weightMem_rd_en),
    .weightMem_rd_addr         (weightMem_rd_addr),
    .fifo_wr_en                (fifo_wr_en),
    .fifo_drain_en             (fifo_drain_en),
    .inputMem_rd_en            (inputMem_rd_en),
    .inputMem_rd_addr          (inputMem_rd_addr),
    .outputMem_wr_en           (outputMem_wr_en),
    .outputMem_wr_addr         (outputMem_wr_addr),
    .accum_clear               (accum_clear),
    .accum_row                 (accum_row),
    .accum_col                 (accum_col),
    .dim_2_q                   (dim_2_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Issue one command, then watch it cycle by cycle until done (bounded).
  task automatic run_cmd(input logic [2:0] op, input logic [3:0] d1, input logic [3:0] d2,
                         input logic [3:0] d3, input logic [7:0] a, input logic [2:0] r,
                         input logic [2:0] c, input int mid_start);
    logic prev_rd;
    @(negedge clk);
    start = 1'b1; opcode = op; dim_1 = d1; dim_2 = d2; dim_3 = d3; addr_1 = a;
    row_in = r; col_in = c;
    @(negedge clk);
    start = 1'b0;
    done_cyc = 0; n_done = 0; n_wrd = 0; n_fwr = 0; lag_err = 0; n_drain = 0;
    n_inrd = 0; n_outwr = 0; n_clear = 0; n_any_en = 0; rc_err = 0; prev_rd = 1'b0;
    fr_k1 = 1'b0; fr_done = 1'b0; busy_done = 1'b0;
    for (int k = 1; k <= 64 && done_cyc == 0; k++) begin
      if (k > 1) @(negedge clk);
      if (k == mid_start) begin
        start = 1'b1; opcode = 3'b001; addr_1 = 8'hAA;
      end else begin
        start = 1'b0;
      end
      if (k == 1) fr_k1 = fifo_ready;
      if (weightMem_rd_en) begin
        if (n_wrd < 32) w_addr[n_wrd] = weightMem_rd_addr;
        n_wrd++;
      end
      if (fifo_wr_en) n_fwr++;
      if (fifo_wr_en !== prev_rd) lag_err++;
      prev_rd = weightMem_rd_en;
      if (fifo_drain_en) n_drain++;
      if (inputMem_rd_en) begin
        if (n_inrd < 32) i_addr[n_inrd] = inputMem_rd_addr;
        n_inrd++;
      end
      if (outputMem_wr_en) begin
        if (n_outwr < 32) o_addr[n_outwr] = outputMem_wr_addr;
        n_outwr++;
        if (accum_row !== r || accum_col !== c) rc_err++;
      end
      if (accum_clear) n_clear++;
      if (weightMem_rd_en | fifo_wr_en | fifo_drain_en | inputMem_rd_en | outputMem_wr_en | accum_clear)
        n_any_en++;
      if (done) begin
        done_cyc = k; n_done++; fr_done = fifo_ready; busy_done = busy;
      end
    end
    start = 1'b0;
    @(negedge clk);
    busy_after = busy;
    done_after = done;
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; opcode = 3'b000; dim_1 = 4'h0; dim_2 = 4'h0; dim_3 = 4'h0;
    addr_1 = 8'h00; row_in = 3'd0; col_in = 3'd0;
    #12;
    check_val("rst_done", {31'd0, done}, 32'd0);
    check_val("rst_busy", {31'd0, busy}, 32'd0);
    check_val("rst_fifo_ready", {31'd0, fifo_ready}, 32'd0);
    check_val("rst_cmd_err", {31'd0, cmd_err}, 32'd0);
    check_val("rst_dim2", {28'd0, dim_2_q}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // CLEAR
    run_cmd(3'b111, 4'h0, 4'h0, 4'h0, 8'h00, 3'd0, 3'd0, 0);
    check_val("clr_done_cyc", done_cyc, 32'd2);
    check_val("clr_pulses", n_clear, 32'd1);
    check_val("clr_fifo_ready", {31'd0, fr_done}, 32'd0);
    check_val("clr_busy_in_done", {31'd0, busy_done}, 32'd1);
    check_val("clr_busy_after", {31'd0, busy_after}, 32'd0);
    check_val("clr_done_after", {31'd0, done_after}, 32'd0);

    // DRAIN with an empty FIFO is refused
    run_cmd(3'b010, 4'h0, 4'h0, 4'h0, 8'h00, 3'd0, 3'd0, 0);
    check_val("drain0_done_cyc", done_cyc, 32'd1);
    check_val("drain0_drains", n_drain, 32'd0);
    check_val("drain0_cmd_err", {31'd0, cmd_err}, 32'd1);

    // FILL full tile from 0x00
    run_cmd(3'b001, 4'hF, 4'h0, 4'h0, 8'h00, 3'd0, 3'd0, 0);
    check_val("fill16_reads", n_wrd, 32'd16);
    check_val("fill16_writes", n_fwr, 32'd16);
    check_val("fill16_lag", lag_err, 32'd0);
    for (int i = 0; i < 16; i++) check_val($sformatf("fill16_addr%0d", i), {24'd0, w_addr[i]}, i);
    check_val("fill16_done_cyc", done_cyc, 32'd18);
    check_val("fill16_done_pulses", n_done, 32'd1);
    check_val("fill16_fifo_ready", {31'd0, fr_done}, 32'd1);
    check_val("fill16_cmd_err_clr", {31'd0, cmd_err}, 32'd0);

    // DRAIN after fill
    run_cmd(3'b010, 4'h0, 4'h0, 4'h0, 8'h00, 3'd0, 3'd0, 0);
    check_val("drain_cycles", n_drain, 32'd16);
    check_val("drain_fr_first", {31'd0, fr_k1}, 32'd0);
    check_val("drain_done_cyc", done_cyc, 32'd17);
    check_val("drain_cmd_err", {31'd0, cmd_err}, 32'd0);

    // FILL with address wrap
    run_cmd(3'b001, 4'h3, 4'h0, 4'h0, 8'hFE, 3'd0, 3'd0, 0);
    check_val("fillw_reads", n_wrd, 32'd4);
    check_val("fillw_addr0", {24'd0, w_addr[0]}, 32'h0FE);
    check_val("fillw_addr1", {24'd0, w_addr[1]}, 32'h0FF);
    check_val("fillw_addr2", {24'd0, w_addr[2]}, 32'h000);
    check_val("fillw_addr3", {24'd0, w_addr[3]}, 32'h001);
    check_val("fillw_writes", n_fwr, 32'd4);
    check_val("fillw_lag", lag_err, 32'd0);
    check_val("fillw_done_cyc", done_cyc, 32'd6);

    // MULT with a start pulsed mid-op (must be ignored)
    run_cmd(3'b011, 4'h1, 4'h0, 4'h0, 8'h20, 3'd0, 3'd0, 5);
    check_val("mult_reads", n_inrd, 32'd2);
    check_val("mult_addr0", {24'd0, i_addr[0]}, 32'h20);
    check_val("mult_addr1", {24'd0, i_addr[1]}, 32'h21);
    check_val("mult_quiet_flush", n_any_en, 32'd2);
    check_val("mult_done_cyc", done_cyc, 32'd34);
    check_val("mult_ignored_start", n_wrd, 32'd0);
    check_val("mult_busy_after", {31'd0, busy_after}, 32'd0);

    // STORE
    run_cmd(3'b100, 4'h0, 4'h7, 4'h2, 8'h10, 3'd2, 3'd5, 0);
    check_val("store_writes", n_outwr, 32'd3);
    check_val("store_addr0", {24'd0, o_addr[0]}, 32'h10);
    check_val("store_addr1", {24'd0, o_addr[1]}, 32'h11);
    check_val("store_addr2", {24'd0, o_addr[2]}, 32'h12);
    check_val("store_rowcol_stable", rc_err, 32'd0);
    check_val("store_row", {29'd0, accum_row}, 32'd2);
    check_val("store_col", {29'd0, accum_col}, 32'd5);
    check_val("store_dim2", {28'd0, dim_2_q}, 32'd7);
    check_val("store_done_cyc", done_cyc, 32'd4);

    // Illegal opcodes
    run_cmd(3'b101, 4'h0, 4'h0, 4'h0, 8'h00, 3'd0, 3'd0, 0);
    check_val("op101_done_cyc", done_cyc, 32'd1);
    check_val("op101_cmd_err", {31'd0, cmd_err}, 32'd1);
    run_cmd(3'b110, 4'h0, 4'h0, 4'h0, 8'h00, 3'd0, 3'd0, 0);
    check_val("op110_done_cyc", done_cyc, 32'd1);
    check_val("op110_any_en", n_any_en, 32'd0);

    // Reset in the middle of a FILL
    @(negedge clk);
    start = 1'b1; opcode = 3'b001; dim_1 = 4'hF; addr_1 = 8'h40;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check_val("midrst_pre_rd", {31'd0, weightMem_rd_en}, 32'd1);
    reset = 1'b0;
    #1;
    check_val("midrst_rd_en", {31'd0, weightMem_rd_en}, 32'd0);
    check_val("midrst_fifo_wr", {31'd0, fifo_wr_en}, 32'd0);
    check_val("midrst_busy", {31'd0, busy}, 32'd0);
    check_val("midrst_fifo_ready", {31'd0, fifo_ready}, 32'd0);
    check_val("midrst_cmd_err", {31'd0, cmd_err}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    n_done = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done | busy | weightMem_rd_en) n_done++;
    end
    check_val("midrst_no_done", n_done, 32'd0);

    run_cmd(3'b000, 4'h0, 4'h0, 4'h0, 8'h00, 3'd0, 3'd0, 0);
    check_val("nop_done_cyc", done_cyc, 32'd1);
    check_val("nop_busy_after", {31'd0, busy_after}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tpu_cmd_ctrl.md
Name: tpu_cmd_ctrl

Overview:
- Command responder inside the TPU top. It receives a host command (start, opcode, dims, addr_1, submatrix row/col) and sequences the weight memory, weight FIFO, input memory, systolic array and output memory.
- It answers each accepted command with a one-cycle done pulse.
- It is the TPU-side end of the host start/opcode/done protocol that benches and the host controller drive.

Parameters:
- WIDTH_HEIGHT, 16, systolic array edge; weight FIFO depth.
- DATA_WIDTH, 8, element width. Not used in datapath; kept for top-level parameter passthrough.
- MAX_MAT_WH, 128, largest matrix edge; sets submat index width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  command strobe; sampled only in IDLE.
- opcode  in  3  command code.
- dim_1  in  $clog2(WIDTH_HEIGHT)  row count minus 1.
- dim_2  in  $clog2(WIDTH_HEIGHT)  inner dim minus 1 (latched, forwarded).
- dim_3  in  $clog2(WIDTH_HEIGHT)  output row count minus 1.
- addr_1  in  8  base memory address.
- accum_table_submat_row_in  in  $clog2(MAX_MAT_WH/WIDTH_HEIGHT)  accumulator tile row.
- accum_table_submat_col_in  in  $clog2(MAX_MAT_WH/WIDTH_HEIGHT)  accumulator tile col.
- done  out  1  one-cycle completion pulse.
- busy  out  1  high from the cycle after accept until done inclusive.
- cmd_err  out  1  sticky; set by an illegal opcode; cleared by the next legal accept.
- fifo_ready  out  1  high when the weight FIFO holds a full filled tile.
- weightMem_rd_en  out  1  weight memory read.
- weightMem_rd_addr  out  8  weight memory address.
- fifo_wr_en  out  1  push to the weight FIFO; 1 cycle after weightMem_rd_en (memory latency 1).
- fifo_drain_en  out  1  shift FIFO into the array.
- inputMem_rd_en  out  1  input memory read.
- inputMem_rd_addr  out  8  input memory address.
- outputMem_wr_en  out  1  output memory write.
- outputMem_wr_addr  out  8  output memory address.
- accum_clear  out  1  clear the accumulator table.
- accum_row  out  submat width  latched tile row.
- accum_col  out  submat width  latched tile col.
- dim_2_q  out  $clog2(WIDTH_HEIGHT)  latched dim_2.

Behaviour:
- Reset (reset=0, async): state IDLE; all outputs 0; latched command registers 0; fifo_ready=0.
- Accept: in IDLE, a rising clk with start=1 latches opcode, dims, addr_1, row and col. The next cycle enters the op state with busy=1. A start while busy is ignored; no queueing.
- Opcodes:
  - 000 NOP: straight to DONE.
  - 001 FILL: dim_1+1 cycles of weightMem_rd_en, addresses addr_1, addr_1+1, ... in 8-bit wrap. fifo_wr_en follows each read by one cycle. fifo_ready=1 from the cycle after the last fifo_wr_en.
  - 010 DRAIN: fifo_drain_en for exactly WIDTH_HEIGHT cycles; fifo_ready=0 from the first drain cycle. If fifo_ready=0 at accept, skip to DONE and set cmd_err.
  - 011 MULT: dim_1+1 cycles of inputMem_rd_en from addr_1 with wrap. Then a flush wait of 2*WIDTH_HEIGHT-1 cycles with all enables 0.
  - 100 STORE: dim_3+1 cycles of outputMem_wr_en, addresses addr_1 upward with wrap. accum_row and accum_col stay stable throughout.
  - 111 CLEAR: accum_clear for 1 cycle; fifo_ready cleared.
  - 101 and 110 are illegal: DONE next cycle, cmd_err=1.
- States: IDLE, FILL, FILL_TAIL (1 cycle for the final fifo_wr_en), DRAIN, MULT_RD, MULT_FLUSH, STORE, CLEAR, DONE.
  - Every op state goes to DONE. DONE goes to IDLE.
  - done=1 only in DONE. busy drops the cycle after DONE.
  - A new start is accepted no earlier than the IDLE cycle following DONE.
- Counters: one 8-bit cycle counter, loaded at state entry and compared to its terminal count. Address equals latched addr_1 plus count, truncated to 8 bits.
- dim=0 means 1 row; dim=all-ones means WIDTH_HEIGHT rows.
- Reset mid-operation: immediate return to IDLE, all outputs 0, fifo_ready=0. No done is emitted for the aborted command.

Test Plan:
- Reset then opcode 111 start pulse -> accum_clear high exactly 1 cycle, done 2 cycles after the accept edge, fifo_ready=0, busy low afterwards.
- Opcode 001, dim_1=4'hF, addr_1=8'h00 -> weightMem_rd_addr 0x00..0x0F on 16 consecutive cycles, 16 fifo_wr_en each lagging by 1, fifo_ready=1, single done pulse.
- Opcode 001, dim_1=3, addr_1=8'hFE -> addresses FE, FF, 00, 01 (wrap), 4 writes.
- Opcode 010 with fifo_ready=0 -> no fifo_drain_en, done next cycle, cmd_err=1. Opcode 010 after a fill -> exactly 16 drain cycles, fifo_ready clears on the first.
- Opcode 011, dim_1=1, then opcode 100, dim_3=2, addr_1=8'h10, row=2, col=5 -> 2 input reads, 31 idle flush cycles, then outputMem_wr_addr 10, 11, 12 with accum_row=2 and accum_col=5. A start pulsed mid-op is ignored.
- Opcode 101 -> done 1 cycle later with cmd_err=1. Assert reset mid-FILL -> all enables 0 immediately, no done, next command accepted normally.
